// File: rtl/mem_fifo_ctrl.sv
// Streaming FIFO controller driving an external single-port mem as storage,
// with a registered output stage; capacity is DEPTH mem words plus the output register.
module mem_fifo_ctrl #(
  parameter int ADDR = 4,
  parameter int WORD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WORD-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] out_data,
  output logic [ADDR-1:0] mem_addr,
  output logic [WORD-1:0] mem_data_in,
  output logic            mem_wr,
  input  logic [WORD-1:0] mem_data_out,
  output logic [ADDR:0]   level
);

  localparam logic [ADDR:0] DEPTH_W = (ADDR+1)'(1 << ADDR);

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_REFILL,
    OP_BYPASS,
    OP_WRITE
  } op_t;

  op_t             op;
  logic [ADDR-1:0] rd_ptr;
  logic [ADDR-1:0] wr_ptr;
  logic [ADDR:0]   mcount;
  logic            slot_free;

  assign slot_free = !out_valid || out_ready;

  // One mem access per cycle; a pending refill always beats an upstream write.
  always_comb begin
    op = OP_IDLE;
    if (rst_n) begin
      if (slot_free && mcount != '0)
        op = OP_REFILL;
      else if (slot_free && in_valid)
        op = OP_BYPASS;
      else if (!slot_free && in_valid && mcount < DEPTH_W)
        op = OP_WRITE;
    end
  end

  always_comb begin
    in_ready    = (op == OP_BYPASS) || (op == OP_WRITE);
    mem_wr      = (op == OP_WRITE);
    mem_addr    = (op == OP_WRITE) ? wr_ptr : rd_ptr;
    mem_data_in = in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      mcount    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (op)
        OP_REFILL: begin
          out_data  <= mem_data_out;
          out_valid <= 1'b1;
          rd_ptr    <= rd_ptr + 1'b1;
          mcount    <= mcount - 1'b1;
        end
        OP_BYPASS: begin
          out_data  <= in_data;
          out_valid <= 1'b1;
        end
        OP_WRITE: begin
          wr_ptr <= wr_ptr + 1'b1;
          mcount <= mcount + 1'b1;
        end
        default: begin
          if (out_valid && out_ready)
            out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign level = mcount + {{ADDR{1'b0}}, out_valid};

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Self-checking bench for mem_fifo_ctrl (ADDR=2, WORD=4) against a queue-based
// model of the held words, with a behavioural single-port mem attached.
module tb_mem_fifo_ctrl;

  localparam int ADDR  = 2;
  localparam int WORD  = 4;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [WORD-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [WORD-1:0] out_data;
  logic [ADDR-1:0] mem_addr;
  logic [WORD-1:0] mem_data_in;
  logic            mem_wr;
  logic [WORD-1:0] mem_data_out;
  logic [ADDR:0]   level;

  logic [WORD-1:0] mem_store [DEPTH];

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_wr) mem_store[mem_addr] <= mem_data_in;
  assign mem_data_out = mem_store[mem_addr];

  mem_fifo_ctrl #(.ADDR(ADDR), .WORD(WORD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_wr       (mem_wr),
    .mem_data_out (mem_data_out),
    .level        (level)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: every held word in acceptance order, plus counts of mem writes/reads since reset.
  logic [WORD-1:0] q [$];
  int   wr_count = 0;
  int   rd_count = 0;
  logic last_acc;
  int   wrap_passes = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic iv, input logic [WORD-1:0] id, input logic ordy);
    int   ov, mc;
    logic sf, acc, wr, rf;
    rst_n = r; in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    ov  = (q.size() > 0) ? 1 : 0;
    mc  = q.size() - ov;
    sf  = (ov == 0) || ordy;
    acc = r && iv && ((sf && mc == 0) || (!sf && mc < DEPTH));
    wr  = acc && !sf;
    rf  = r && sf && mc > 0;
    check("in_ready", in_ready, acc);
    check("mem_wr", mem_wr, wr);
    check("out_valid", out_valid, ov);
    check("level", level, q.size());
    if (ov != 0) check("out_data", out_data, q[0]);
    if (wr) begin
      check("wr_addr", mem_addr, wr_count % DEPTH);
      check("mem_data_in", mem_data_in, id);
    end else if (r) begin
      check("rd_addr", mem_addr, rd_count % DEPTH);
    end
    last_acc = acc;
    @(posedge clk);
    if (!r) begin
      q.delete();
      wr_count = 0;
      rd_count = 0;
    end else begin
      if (rf) rd_count++;
      if (wr) begin
        if (wr_count % DEPTH == DEPTH - 1) wrap_passes++;
        wr_count++;
      end
      if (ov != 0 && ordy) void'(q.pop_front());
      if (acc) q.push_back(id);
    end
    @(negedge clk);
  endtask

  initial begin
    int idx;
    int cyc;
    int p_in, p_out;
    for (int i = 0; i < DEPTH; i++) mem_store[i] = '0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    #1;
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_wr", mem_wr, 0);
    @(negedge clk);

    // Bypass
    step(1, 1, 4'd7, 0);
    step(1, 0, 4'd0, 0);
    check("byp_data", out_data, 7);
    check("byp_level", level, 1);

    // Fill, then drain
    step(0, 0, 4'd0, 0);
    for (int k = 1; k <= 5; k++) step(1, 1, 4'(k), 0);
    step(1, 1, 4'd6, 0);
    check("fill_rejects6", last_acc, 0);
    check("fill_level", level, 5);
    for (int k = 0; k < 6; k++) step(1, 0, 4'd0, 1);
    check("drain_level", level, 0);

    // Contention: mcount=2 with the head draining while 9 is offered
    step(0, 0, 4'd0, 0);
    for (int k = 1; k <= 3; k++) step(1, 1, 4'(k), 0);
    cyc = 0;
    do begin
      step(1, 1, 4'd9, 1);
      cyc++;
    end while (!last_acc && cyc < 10);
    check("cont_accept_cycle", cyc, 3);
    for (int k = 0; k < 3; k++) step(1, 0, 4'd0, 1);

    // Wrap: ten words with out_ready toggling every 3 cycles
    step(0, 0, 4'd0, 0);
    idx = 0; cyc = 0;
    while ((idx < 10 || q.size() > 0) && cyc < 200) begin
      step(1, idx < 10, 4'(idx), ((cyc / 3) % 2) == 1);
      if (last_acc) idx++;
      cyc++;
    end
    check("wrap_done", (idx == 10 && q.size() == 0) ? 1 : 0, 1);

    // Reset mid-operation
    for (int k = 1; k <= 3; k++) step(1, 1, 4'(k + 10), 0);
    check("mid_level", level, 3);
    step(0, 1, 4'd15, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_valid", out_valid, 0);
    step(1, 1, 4'd4, 0);
    step(1, 0, 4'd0, 0);
    check("mid_first", out_data, 4);

    // Randomized traffic at varying densities
    for (int blk = 0; blk < 8; blk++) begin
      p_in  = $urandom_range(10, 95);
      p_out = $urandom_range(10, 95);
      for (int i = 0; i < 400; i++) begin
        step(($urandom_range(0, 299) != 0),
             ($urandom_range(0, 99) < p_in),
             4'($urandom),
             ($urandom_range(0, 99) < p_out));
      end
    end
    check("wr_ptr_wraps", (wrap_passes >= 2) ? 1 : 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
